// File: rtl/riscv_pipeline_pkg.sv
// Shared types for the pipeline hazard controller.
//   hazard_state_t : RUN (normal issue) / MD_WAIT (EX frozen on a MUL/DIV)
//   REG_X0         : architectural zero register, never a hazard source
package riscv_pipeline_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hazard_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_reg_match.sv
// Register dependency comparator.
// Flags when a producer destination (rd) feeds a source that the consumer
// actually reads. x0 never matches.
//   rd         : producer destination
//   rs1/rs2    : consumer sources
//   use1/use2  : consumer reads rs1 / rs2
//   hit        : dependency present
module hazard_reg_match
  import riscv_pipeline_pkg::*;
(
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use1,
  input  logic       use2,
  output logic       hit
);

  assign hit = (rd != REG_X0) &&
               ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Covers hazards that forwarding cannot: load-use, branch operands still in
// flight (EX result or MEM load), and multi-cycle MUL/DIV occupying EX.
//   in : ID sources/usage/type, branch_taken, EX/MEM producer info,
//        EX_md_start, md_done
//   out: PC_stall, IF_ID_stall, ID_EX_bubble, EX_stall, EX_MEM_bubble,
//        IF_ID_flush (all combinational), stall_cycles (saturating perf
//        counter), md_timeout (sticky watchdog flag)
module pipeline_hazard_controller
  import riscv_pipeline_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int MD_MAX_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             ID_is_store,
  input  logic             ID_is_branch,
  input  logic             branch_taken,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_Rd,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_Rd,
  input  logic             EX_md_start,
  input  logic             md_done,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_bubble,
  output logic             EX_stall,
  output logic             EX_MEM_bubble,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             md_timeout
);

  localparam int MDC_W = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [MDC_W-1:0] MD_MAX = MDC_W'(MD_MAX_CYCLES);

  hazard_state_t    state;
  logic [MDC_W-1:0] md_cnt;
  logic             lu_hit, exb_hit, memb_hit;
  logic             load_use, br_hazard, md_stall, id_stall;

  // Store data (Rs2) of a store is forwarded from MEM, so it does not
  // count as a load-use consumer.
  hazard_reg_match u_load_use (
    .rd(EX_Rd), .rs1(ID_Rs1), .rs2(ID_Rs2),
    .use1(ID_uses_rs1), .use2(ID_uses_rs2 & ~ID_is_store), .hit(lu_hit)
  );

  // Branches resolve in ID and need both operands there, store or not.
  hazard_reg_match u_ex_branch (
    .rd(EX_Rd), .rs1(ID_Rs1), .rs2(ID_Rs2),
    .use1(ID_uses_rs1), .use2(ID_uses_rs2), .hit(exb_hit)
  );

  hazard_reg_match u_mem_branch (
    .rd(MEM_Rd), .rs1(ID_Rs1), .rs2(ID_Rs2),
    .use1(ID_uses_rs1), .use2(ID_uses_rs2), .hit(memb_hit)
  );

  assign load_use  = EX_MemRead & lu_hit;
  assign br_hazard = ID_is_branch &
                     ((EX_RegWrite & exb_hit) | (MEM_MemRead & memb_hit));

  // A start with a same-cycle done is a single-cycle op: no freeze.
  assign md_stall = ~md_done &
                    (((state == RUN) & EX_md_start) | (state == MD_WAIT));
  assign id_stall = ~md_stall & (load_use | br_hazard);

  assign PC_stall      = md_stall | id_stall;
  assign IF_ID_stall   = md_stall | id_stall;
  assign ID_EX_bubble  = id_stall;
  assign EX_stall      = md_stall;
  assign EX_MEM_bubble = md_stall;
  // A stalled branch has not resolved yet, so it must not squash.
  assign IF_ID_flush   = branch_taken & ~PC_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      md_cnt       <= '0;
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (PC_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      case (state)
        RUN: begin
          md_cnt <= '0;
          if (EX_md_start && !md_done) state <= MD_WAIT;
        end
        MD_WAIT: begin
          if (md_done) begin
            state  <= RUN;
            md_cnt <= '0;
          end else begin
            if (md_cnt != MD_MAX) md_cnt <= md_cnt + 1'b1;
            // Flag raised on the edge where the wait count reaches the limit.
            if (md_cnt >= MD_MAX - 1'b1) md_timeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 4;
  localparam int MDMAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ID_Rs1, ID_Rs2, EX_Rd, MEM_Rd;
  logic ID_uses_rs1, ID_uses_rs2, ID_is_store, ID_is_branch, branch_taken;
  logic EX_MemRead, EX_RegWrite, MEM_MemRead, EX_md_start, md_done;
  logic PC_stall, IF_ID_stall, ID_EX_bubble, EX_stall, EX_MEM_bubble, IF_ID_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic md_timeout;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.CNT_W(CNT_W), .MD_MAX_CYCLES(MDMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .ID_is_store(ID_is_store), .ID_is_branch(ID_is_branch), .branch_taken(branch_taken),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd), .EX_md_start(EX_md_start), .md_done(md_done),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_bubble(ID_EX_bubble),
    .EX_stall(EX_stall), .EX_MEM_bubble(EX_MEM_bubble), .IF_ID_flush(IF_ID_flush),
    .stall_cycles(stall_cycles), .md_timeout(md_timeout)
  );

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1, rs2;
    logic       u1, u2, st, br, bt;
    logic       ex_mr, ex_rw;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic       mds, mdd;
  } stim_t;

  typedef struct {
    int               id;
    logic [5:0]       ctl;  // {PC,IF_ID,ID_EX_bub,EX_stall,EX_MEM_bub,flush}
    logic [CNT_W-1:0] sc;
    logic             to;
  } exp_t;

  exp_t q[$];
  stim_t s;
  int checks = 0, errors = 0, vec_id = 0;
  logic [CNT_W-1:0] sc_model = '0;
  bit drv_done = 0;

  task automatic clr();
    s = '0;
    s.rst_n = 1'b1;
  endtask

  // Apply staged stimulus at negedge, then queue the hand-computed response.
  task automatic step(input logic [5:0] ctl, input logic to);
    exp_t e;
    @(negedge clk);
    rst_n = s.rst_n;  ID_Rs1 = s.rs1;  ID_Rs2 = s.rs2;
    ID_uses_rs1 = s.u1;  ID_uses_rs2 = s.u2;  ID_is_store = s.st;
    ID_is_branch = s.br;  branch_taken = s.bt;
    EX_MemRead = s.ex_mr;  EX_RegWrite = s.ex_rw;  EX_Rd = s.ex_rd;
    MEM_MemRead = s.mem_mr;  MEM_Rd = s.mem_rd;
    EX_md_start = s.mds;  md_done = s.mdd;
    if (!s.rst_n) sc_model = '0;
    #1;
    e.id = vec_id; e.ctl = ctl; e.sc = sc_model; e.to = to;
    q.push_back(e);
    vec_id++;
    if (ctl[5] && s.rst_n && sc_model != '1) sc_model = sc_model + 1'b1;
  endtask

  task automatic ld5_ex();
    s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5'd5;
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {PC_stall, IF_ID_stall, ID_EX_bubble, EX_stall, EX_MEM_bubble, IF_ID_flush};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl vec %0d: got %b want %b", e.id, act, e.ctl);
        end
        checks++;
        if (stall_cycles !== e.sc) begin
          errors++;
          $display("FAIL stall_cycles vec %0d: got %0d want %0d", e.id, stall_cycles, e.sc);
        end
        checks++;
        if (md_timeout !== e.to) begin
          errors++;
          $display("FAIL md_timeout vec %0d: got %b want %b", e.id, md_timeout, e.to);
        end
      end
    end
  end

  initial begin
    // reset state, then idle
    clr(); s.rst_n = 0;                          step(6'b000000, 0);
    clr();                                       step(6'b000000, 0);
    // lw x5 ; add x6,x5,x1 -> one load-use stall
    clr(); ld5_ex(); s.rs1 = 5; s.rs2 = 1; s.u1 = 1; s.u2 = 1; step(6'b111000, 0);
    clr(); s.mem_mr = 1; s.mem_rd = 5; s.rs1 = 5; s.rs2 = 1; s.u1 = 1; s.u2 = 1;
                                                 step(6'b000000, 0);
    // lw x5 ; sw x5,0(x2): store data forwarded, no stall
    clr(); ld5_ex(); s.rs1 = 2; s.rs2 = 5; s.u1 = 1; s.u2 = 1; s.st = 1; step(6'b000000, 0);
    // load to x0 with consumer of x0
    clr(); s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 0; s.rs1 = 0; s.u1 = 1; step(6'b000000, 0);
    // Rs2 dependency of a non-store, and same Rs2 unused
    clr(); ld5_ex(); s.rs1 = 1; s.rs2 = 5; s.u1 = 1; s.u2 = 1; step(6'b111000, 0);
    clr(); ld5_ex(); s.rs1 = 1; s.rs2 = 5; s.u1 = 1;            step(6'b000000, 0);
    // lw x5 ; beq x5,x0 taken: two stall cycles, no flush until resolved
    clr(); ld5_ex(); s.br = 1; s.bt = 1; s.rs1 = 5; s.u1 = 1; s.u2 = 1; step(6'b111000, 0);
    clr(); s.mem_mr = 1; s.mem_rd = 5; s.br = 1; s.bt = 1; s.rs1 = 5; s.u1 = 1; s.u2 = 1;
                                                 step(6'b111000, 0);
    clr(); s.br = 1; s.bt = 1; s.rs1 = 5; s.u1 = 1; s.u2 = 1; step(6'b000001, 0);
    clr();                                       step(6'b000000, 0);
    // ALU result in EX feeding a branch stalls; a plain ALU consumer does not
    clr(); s.ex_rw = 1; s.ex_rd = 7; s.br = 1; s.rs2 = 7; s.u2 = 1; step(6'b111000, 0);
    clr(); s.ex_rw = 1; s.ex_rd = 7; s.rs2 = 7; s.u2 = 1;           step(6'b000000, 0);
    // non-load in MEM feeding a branch is forwarded
    clr(); s.mem_rd = 7; s.br = 1; s.rs2 = 7; s.u2 = 1;            step(6'b000000, 0);
    // single-cycle MUL/DIV, then stray md_done in RUN
    clr(); s.mds = 1; s.mdd = 1;                 step(6'b000000, 0);
    clr();                                       step(6'b000000, 0);
    clr(); s.mdd = 1;                            step(6'b000000, 0);
    // MUL/DIV done after 5 wait cycles: 6 stall cycles, watchdog trips after 4
    clr(); s.mds = 1;                            step(6'b110110, 0);
    clr();                                       step(6'b110110, 0);
    clr(); s.mds = 1;                            step(6'b110110, 0);
    clr(); ld5_ex(); s.rs1 = 5; s.u1 = 1; s.bt = 1; step(6'b110110, 0);
    clr();                                       step(6'b110110, 0);
    clr();                                       step(6'b110110, 1);
    clr(); s.mdd = 1;                            step(6'b000000, 1);
    clr();                                       step(6'b000000, 1);
    // reset while in MD_WAIT
    clr(); s.mds = 1;                            step(6'b110110, 1);
    clr();                                       step(6'b110110, 1);
    clr(); s.rst_n = 0;                          step(6'b000000, 0);
    clr();                                       step(6'b000000, 0);
    // counter saturation at 15
    for (int i = 0; i < 17; i++) begin
      clr(); ld5_ex(); s.rs1 = 5; s.u1 = 1;      step(6'b111000, 0);
    end
    clr();                                       step(6'b000000, 0);
    clr();                                       step(6'b000000, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    checks++;
    if (sc_model != 4'hF) begin
      errors++;
      $display("FAIL sat_model: got %0d want 15", sc_model);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
